// File: rtl/ps2_kbd_poly.sv
// PS/2 keyboard front end: filtered framing, 13-key piano mask, last-note priority, select counter; KBD_PARITY_CHK_EN enforces odd parity.
// Key events land one cycle after the byte completes (two after the stop-bit strobe); no backpressure, all events are single-cycle pulses.
`timescale 1ns/1ps
module ps2_kbd_poly #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SEL_W       = 2,
  parameter int SEL_WRAP    = 1
) (
  input  logic             clk,
  input  logic             ar,
  input  logic             ps2_clk,
  input  logic             ps2_dat,
  output logic [12:0]      key_mask,
  output logic [3:0]       key_val,
  output logic             key_on,
  output logic             ev_valid,
  output logic [3:0]       ev_key,
  output logic             ev_make,
  output logic [SEL_W-1:0] select,
  output logic             frame_err
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]          ck_sync_q, dt_sync_q;
  logic [FILT_LEN-1:0] filt_sr_q;
  logic                filt_clk_q, filt_clk_d;
  logic                ck_s, dt_s, strobe, timeout, par_ok;
  state_t              state_q, state_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                par_q, par_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                byte_vld_q, byte_vld_d;
  logic                ferr_q, ferr_d;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic [12:0]         mask_q, mask_d;
  logic [3:0]          val_q, val_d;
  logic                on_q, on_d;
  logic                ev_vld_q, ev_vld_d;
  logic [3:0]          ev_key_q, ev_key_d;
  logic                ev_make_q, ev_make_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                up_held_q, up_held_d, dn_held_q, dn_held_d;
  logic [4:0]          km;
  logic                key_hit;
  logic [3:0]          key_idx;

  function automatic logic [4:0] map_key(input logic [7:0] code);
    case (code)
      8'h1A: return {1'b1, 4'd0};
      8'h1B: return {1'b1, 4'd1};
      8'h22: return {1'b1, 4'd2};
      8'h21: return {1'b1, 4'd3};
      8'h2B: return {1'b1, 4'd4};
      8'h2A: return {1'b1, 4'd5};
      8'h34: return {1'b1, 4'd6};
      8'h32: return {1'b1, 4'd7};
      8'h31: return {1'b1, 4'd8};
      8'h3B: return {1'b1, 4'd9};
      8'h3A: return {1'b1, 4'd10};
      8'h42: return {1'b1, 4'd11};
      8'h41: return {1'b1, 4'd12};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [3:0] lowest(input logic [12:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 12; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  assign ck_s = ck_sync_q[1];
  assign dt_s = dt_sync_q[1];

  always_comb begin
    filt_clk_d = filt_clk_q;
    if (&filt_sr_q)       filt_clk_d = 1'b1;
    else if (~|filt_sr_q) filt_clk_d = 1'b0;
  end

  assign strobe  = filt_clk_q & ~filt_clk_d;
  assign timeout = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

`ifdef KBD_PARITY_CHK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      ck_sync_q  <= '1;
      dt_sync_q  <= '1;
      filt_sr_q  <= '1;
      filt_clk_q <= 1'b1;
    end else begin
      ck_sync_q  <= {ck_sync_q[0], ps2_clk};
      dt_sync_q  <= {dt_sync_q[0], ps2_dat};
      filt_sr_q  <= {filt_sr_q[FILT_LEN-2:0], ck_s};
      filt_clk_q <= filt_clk_d;
    end
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) state_q <= IDLE;
    else    state_q <= state_d;
  end

  // Timeout has priority over any strobe landing in the same cycle.
  always_comb begin
    state_d = state_q;
    if (timeout) state_d = IDLE;
    else if (strobe) begin
      case (state_q)
        IDLE:    if (!dt_s) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    byte_vld_d = 1'b0;
    ferr_d     = 1'b0;
    if (state_q == IDLE || strobe) wd_d = '0;
    else                           wd_d = wd_q + 1'b1;
    if (timeout) begin
      ferr_d    = 1'b1;
      wd_d      = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (strobe) begin
      case (state_q)
        IDLE:    bit_cnt_d = '0;
        DATA: begin
          shift_d   = {dt_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY:  par_d = dt_s;
        default: begin
          if (dt_s && par_ok) byte_vld_d = 1'b1;
          else                ferr_d     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      byte_vld_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      byte_vld_q <= byte_vld_d;
      ferr_q     <= ferr_d;
    end
  end

  assign km      = map_key(shift_q);
  assign key_hit = km[4];
  assign key_idx = km[3:0];

  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    mask_d    = mask_q;
    val_d     = val_q;
    on_d      = on_q;
    ev_vld_d  = 1'b0;
    ev_key_d  = ev_key_q;
    ev_make_d = ev_make_q;
    sel_d     = sel_q;
    up_held_d = up_held_q;
    dn_held_d = dn_held_q;
    if (timeout) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (shift_q == 8'hE0)      ext_d = 1'b1;
      else if (shift_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ext_q) begin
          if (key_hit) begin
            if (!brk_q && !mask_q[key_idx]) begin
              mask_d[key_idx] = 1'b1;
              ev_vld_d  = 1'b1;
              ev_key_d  = key_idx;
              ev_make_d = 1'b1;
              val_d     = key_idx;
              on_d      = 1'b1;
            end else if (brk_q && mask_q[key_idx]) begin
              mask_d[key_idx] = 1'b0;
              ev_vld_d  = 1'b1;
              ev_key_d  = key_idx;
              ev_make_d = 1'b0;
              // Releasing the sounding note falls back to the lowest still-held key.
              if (mask_d == '0)          on_d  = 1'b0;
              else if (key_idx == val_q) val_d = lowest(mask_d);
            end
          end else if (shift_q == 8'h55) begin
            if (brk_q) up_held_d = 1'b0;
            else if (!up_held_q) begin
              up_held_d = 1'b1;
              if (SEL_WRAP != 0 || sel_q != SEL_MAX) sel_d = sel_q + 1'b1;
            end
          end else if (shift_q == 8'h4E) begin
            if (brk_q) dn_held_d = 1'b0;
            else if (!dn_held_q) begin
              dn_held_d = 1'b1;
              if (SEL_WRAP != 0 || sel_q != '0) sel_d = sel_q - 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      mask_q    <= '0;
      val_q     <= '0;
      on_q      <= 1'b0;
      ev_vld_q  <= 1'b0;
      ev_key_q  <= '0;
      ev_make_q <= 1'b0;
      sel_q     <= '0;
      up_held_q <= 1'b0;
      dn_held_q <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      mask_q    <= mask_d;
      val_q     <= val_d;
      on_q      <= on_d;
      ev_vld_q  <= ev_vld_d;
      ev_key_q  <= ev_key_d;
      ev_make_q <= ev_make_d;
      sel_q     <= sel_d;
      up_held_q <= up_held_d;
      dn_held_q <= dn_held_d;
    end
  end

  assign key_mask  = mask_q;
  assign key_val   = val_q;
  assign key_on    = on_q;
  assign ev_valid  = ev_vld_q;
  assign ev_key    = ev_key_q;
  assign ev_make   = ev_make_q;
  assign select    = sel_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_kbd_poly.sv
// Bench for ps2_kbd_poly: directed PS/2 frames, expected events/select/errors queued, negedge monitor compares.
`timescale 1ns/1ps
module tb_ps2_kbd_poly;
  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        ar = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [12:0] key_mask;
  logic [3:0]  key_val;
  logic        key_on;
  logic        ev_valid;
  logic [3:0]  ev_key;
  logic        ev_make;
  logic [1:0]  select;
  logic        frame_err;

  ps2_kbd_poly #(.FILT_LEN(8), .TIMEOUT_CYC(2000), .SEL_W(2), .SEL_WRAP(1)) dut (
    .clk(clk), .ar(ar), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .key_mask(key_mask), .key_val(key_val), .key_on(key_on),
    .ev_valid(ev_valid), .ev_key(ev_key), .ev_make(ev_make),
    .select(select), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  key;
    logic        make;
    logic [12:0] mask;
    logic [3:0]  val;
    logic        on;
  } ev_t;

  int         checks = 0;
  int         errors = 0;
  ev_t        ev_q[$];
  logic [1:0] sel_q[$];
  int         err_q[$];
  ev_t        mon_e;
  ev_t        mon_got;
  logic [1:0] mon_s;
  logic [1:0] sel_prev = 2'd0;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_clk(HALF / 2);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
    wait_clk(HALF / 2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ par_bad);
    send_bit(1'b1);
    wait_clk(100);
  endtask

  task automatic key(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic exp_ev(input logic [3:0] k, input logic mk, input logic [12:0] m,
                        input logic [3:0] v, input logic o);
    ev_t e;
    e.key = k; e.make = mk; e.mask = m; e.val = v; e.on = o;
    ev_q.push_back(e);
  endtask

  task automatic reset_checks();
    chk("rst_key_mask", 32'(key_mask), 32'h0);
    chk("rst_key_val", 32'(key_val), 32'h0);
    chk("rst_key_on", 32'(key_on), 32'h0);
    chk("rst_ev_valid", 32'(ev_valid), 32'h0);
    chk("rst_select", 32'(select), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event, error pulse or select change.
  initial begin
    forever begin
      @(negedge clk);
      if (ev_valid) begin
        checks++;
        mon_got = '{ev_key, ev_make, key_mask, key_val, key_on};
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL ev_unexpected got key=%0d make=%0d mask=%h", ev_key, ev_make, key_mask);
        end else begin
          mon_e = ev_q.pop_front();
          if (mon_got !== mon_e) begin
            errors++;
            $display("FAIL ev got key=%0d make=%0d mask=%h val=%0d on=%0d exp key=%0d make=%0d mask=%h val=%0d on=%0d",
                     ev_key, ev_make, key_mask, key_val, key_on,
                     mon_e.key, mon_e.make, mon_e.mask, mon_e.val, mon_e.on);
          end
        end
      end
      if (frame_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL frame_err_unexpected got=1 exp=0");
        end else void'(err_q.pop_front());
      end
      if (select !== sel_prev) begin
        checks++;
        if (sel_q.size() == 0) begin
          errors++;
          $display("FAIL select_unexpected got=%0d exp=%0d", select, sel_prev);
        end else begin
          mon_s = sel_q.pop_front();
          if (select !== mon_s) begin
            errors++;
            $display("FAIL select got=%0d exp=%0d", select, mon_s);
          end
        end
        sel_prev = select;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    ar = 1'b1;
    wait_clk(5);
    #1;
    reset_checks();
    @(negedge clk);
    ar = 1'b0;
    wait_clk(20);

    // First key
    exp_ev(4'd0, 1'b1, 13'h0001, 4'd0, 1'b1);
    key(8'h1A);

    // Second key, typematic repeat, release with fallback
    exp_ev(4'd2, 1'b1, 13'h0005, 4'd2, 1'b1);
    key(8'h22);
    key(8'h22);
    exp_ev(4'd2, 1'b0, 13'h0001, 4'd0, 1'b1);
    key(8'hF0); key(8'h22);
    chk("mask_after_22_release", 32'(key_mask), 32'h1);
    exp_ev(4'd0, 1'b0, 13'h0000, 4'd0, 1'b0);
    key(8'hF0); key(8'h1A);

    // Last key released: key_on drops, key_val holds
    exp_ev(4'd10, 1'b1, 13'h0400, 4'd10, 1'b1);
    key(8'h3A);
    exp_ev(4'd10, 1'b0, 13'h0000, 4'd10, 1'b0);
    key(8'hF0); key(8'h3A);
    chk("val_hold_after_release", 32'(key_val), 32'd10);
    chk("key_on_after_release", 32'(key_on), 32'd0);

    // Select up with wrap; the repeated make must not step it twice
    for (int k = 1; k <= 4; k++) begin
      sel_q.push_back(2'(k));
      key(8'h55);
      key(8'h55);
      key(8'hF0); key(8'h55);
    end
    sel_q.push_back(2'd3);
    key(8'h4E);
    key(8'hF0); key(8'h4E);
    chk("select_after_dn", 32'(select), 32'd3);

    // Abandoned frame after a prefix: timeout error, prefix dropped
    key(8'hE0);
    err_q.push_back(1);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    wait_clk(2100);
    chk("timeout_err_seen", 32'(err_q.size()), 32'd0);
    exp_ev(4'd1, 1'b1, 13'h0002, 4'd1, 1'b1);
    key(8'h1B);

    // Wrong parity on 0x21
`ifdef KBD_PARITY_CHK_EN
    err_q.push_back(1);
    send_byte(8'h21, 1'b1);
    chk("mask_after_bad_parity", 32'(key_mask), 32'h2);
`else
    exp_ev(4'd3, 1'b1, 13'h000A, 4'd3, 1'b1);
    send_byte(8'h21, 1'b1);
    chk("mask_after_bad_parity", 32'(key_mask), 32'hA);
`endif

    // Extended keys are unmapped
    key(8'hE0); key(8'h1A);
    chk("ext_ignored_mask_bit0", 32'(key_mask[0]), 32'd0);

    // Reset mid-frame with a pending prefix
    key(8'hE0);
    send_bit(1'b0);
    send_bit(1'b1);
    sel_q.push_back(2'd0);
    ar = 1'b1;
    wait_clk(5);
    #1;
    reset_checks();
    @(negedge clk);
    ar = 1'b0;
    wait_clk(20);
    exp_ev(4'd0, 1'b1, 13'h0001, 4'd0, 1'b1);
    key(8'h1A);

    wait_clk(200);
    chk("ev_queue_drained", 32'(ev_q.size()), 32'd0);
    chk("err_queue_drained", 32'(err_q.size()), 32'd0);
    chk("sel_queue_drained", 32'(sel_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_poly.md
Name: ps2_kbd_poly

Overview:
- Parametrised PS/2 keyboard front end for the wavetable synth. Fully synchronous to the system clock.
- Performs the following in order:
  - synchronises and glitch-filters the PS/2 clock;
  - frames bytes with stop/parity checking and a watchdog timeout;
  - decodes make/break/extended prefixes into a 13-key piano mask plus a wavetable select counter.
- Adds typematic-repeat suppression, a one-cycle key event stream, and last-note-priority with fallback on release.

Parameters:
- FILT_LEN, 8, filter shift-register length in clk cycles (min 2).
- TIMEOUT_CYC, 50000, clk cycles without a sample strobe before an in-progress frame is abandoned.
- SEL_W, 2, width of the select counter.
- SEL_WRAP, 1, 1 = select wraps at the ends, 0 = select saturates.

Ports:
- clk  in  1  system clock
- ar  in  1  asynchronous reset, active-high
- ps2_clk  in  1  raw PS/2 clock (asynchronous)
- ps2_dat  in  1  raw PS/2 data (asynchronous)
- key_mask  out  13  held piano keys, bit i = key index i
- key_val  out  4  current priority key index 0..12
- key_on  out  1  high while any piano key is held
- ev_valid  out  1  one-cycle pulse per piano key state change
- ev_key  out  4  key index of the event
- ev_make  out  1  1 = press, 0 = release (valid with ev_valid)
- select  out  SEL_W  wavetable select
- frame_err  out  1  one-cycle pulse on framing, parity or timeout error

Behaviour:
- Reset (ar high, async) values:
  - outputs all 0;
  - FSM in IDLE;
  - synchronisers and filter register all 1s, filtered clock 1 (idle line high, so no false edge on release).
- Input path:
  - 2-FF synchronisers on ps2_clk and ps2_dat.
  - Filter: filtered clock goes 1 when FILT_LEN samples are all 1, goes 0 when all 0, otherwise holds.
  - Sample strobe: one-cycle pulse on the filtered clock falling edge; data sampled from synchronised ps2_dat that cycle.
- Frame FSM (advances on strobe only):
  - IDLE: dat=0 -> DATA, bit counter cleared; dat=1 -> stay.
  - DATA: shift LSB first; after 8th bit -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: dat=1 and parity OK -> byte_valid pulse next cycle; otherwise frame_err pulse. Either way -> IDLE.
- Watchdog:
  - Counter cleared on every strobe and held at 0 in IDLE.
  - Outside IDLE, reaching TIMEOUT_CYC-1 -> IDLE, frame_err pulse, partial byte discarded, prefix flags cleared.
- Byte decode (on byte_valid):
  - 0xE0 sets ext; 0xF0 sets brk; no event for either.
  - Any other byte with ext set: ignored (extended keys unmapped), ext and brk cleared.
  - Otherwise map, then clear ext and brk.
  - Piano keys, scan code -> index: 1A Z=0, 1B S=1, 22 X=2, 21 C=3, 2B F=4, 2A V=5, 34 G=6, 32 B=7, 31 N=8, 3B J=9, 3A M=10, 42 K=11, 41 comma=12.
  - Select keys: 55 '=' = SEL_UP, 4E '-' = SEL_DN. All other codes are ignored.
- Piano make/break (ev_valid one cycle after byte_valid; key_mask, key_val and key_on update in the same cycle):
  - Make, bit clear: set bit, ev_valid with ev_make=1, key_val <= index, key_on <= 1.
  - Make, bit already set (typematic repeat): no change, no event.
  - Break, bit set: clear bit, ev_valid with ev_make=0.
    - If the new mask is 0: key_on <= 0 and key_val holds.
    - Else, if index == key_val: key_val <= lowest set bit of the new mask.
  - Break, bit clear: ignored.
- Select keys:
  - Held state tracked internally; only the make that transitions from released to held acts.
  - SEL_UP: +1. SEL_DN: -1.
  - SEL_WRAP=1: modulo 2^SEL_W. SEL_WRAP=0: clamp at 0 and at 2^SEL_W-1.
- Boundaries:
  - Reset mid-frame: FSM to IDLE, flags cleared.
  - Start bit strobe arriving in the same cycle as a watchdog expiry: timeout wins, and the next strobe is re-evaluated from IDLE.

Optional Feature:
- KBD_PARITY_CHK_EN defined: odd parity required; a mismatch in STOP gives frame_err and the byte is dropped.
- Undefined: the parity bit is sampled and ignored; only the stop bit is checked.

Test Plan:
- Reset, then frame 0x1A (half-period 40 clk, FILT_LEN=8) -> ev_valid pulse: ev_key=0, ev_make=1; key_mask=0x0001; key_val=0; key_on=1.
- Press 1A, 22, 22 (repeat), then F0 22 -> exactly 3 events. key_mask=0x0001 at end. key_val: 2 after the 22 press, 0 after its release (fallback).
- Press 3A then F0 3A -> key_mask=0, key_on=0, key_val holds 10.
- SEL_W=2: send 55 x4 with breaks between presses -> select 1,2,3,0 (SEL_WRAP=1), or 1,2,3,3 (SEL_WRAP=0). Send 4E from 0 -> 3 (wrap) or 0 (sat).
- Stop frame after 4 data bits, wait TIMEOUT_CYC -> one frame_err pulse, FSM IDLE, next full 0x1B decodes as key 1.
- With KBD_PARITY_CHK_EN, 0x21 with wrong parity -> frame_err, no event. Macro undefined -> event key 3. E0 1A -> no event.
